// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
module fetch_stage #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
);

    typedef enum logic [1:0] {S_RUN, S_HOLD, S_DROP} state_t;

    localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          r_state, w_state_n;
    logic [XLEN-1:0] r_pc_f, w_pc_f_n;
    logic [XLEN-1:0] r_req_addr, w_req_addr_n;
    logic [XLEN-1:0] r_hold_instr, w_hold_instr_n;
    logic [XLEN-1:0] r_hold_pc, w_hold_pc_n;
    logic [XLEN-1:0] r_instr_d, r_pc_d, r_pcplus4_d;
    logic            r_valid_d;

    logic            w_ifid_load, w_ifid_bubble;
    logic [XLEN-1:0] w_ifid_instr, w_ifid_pc;
    logic [XLEN-1:0] w_target;

    assign w_target = pc_target_e & ALIGN_MASK;

    always_comb begin
        w_state_n      = r_state;
        w_pc_f_n       = r_pc_f;
        w_req_addr_n   = r_req_addr;
        w_hold_instr_n = r_hold_instr;
        w_hold_pc_n    = r_hold_pc;
        w_ifid_load    = 1'b0;
        w_ifid_bubble  = 1'b0;
        w_ifid_instr   = imem_rdata;
        w_ifid_pc      = r_pc_f;
        case (r_state)
            S_RUN: begin
                w_req_addr_n = r_pc_f;
                if (pc_src_e) begin
                    w_pc_f_n      = w_target;
                    w_ifid_bubble = !stall_d;
                    if (!imem_ready) w_state_n = S_DROP;
                end else if (imem_ready) begin
                    w_pc_f_n = r_pc_f + FOUR;
                    // A word that cannot enter IF/ID this cycle is parked, never lost
                    if (stall_d || flush_d) begin
                        w_hold_instr_n = imem_rdata;
                        w_hold_pc_n    = r_pc_f;
                        w_state_n      = S_HOLD;
                    end else begin
                        w_ifid_load = 1'b1;
                    end
                end else begin
                    w_ifid_bubble = !stall_d;
                end
            end
            S_HOLD: begin
                if (pc_src_e) begin
                    w_pc_f_n      = w_target;
                    w_ifid_bubble = !stall_d;
                    w_state_n     = S_RUN;
                end else if (!stall_d && !flush_d) begin
                    w_ifid_load  = 1'b1;
                    w_ifid_instr = r_hold_instr;
                    w_ifid_pc    = r_hold_pc;
                    w_state_n    = S_RUN;
                end
            end
            S_DROP: begin
                if (pc_src_e) w_pc_f_n = w_target;
                if (imem_ready) w_state_n = S_RUN;
                w_ifid_bubble = !stall_d;
            end
            default: w_state_n = S_RUN;
        endcase
        if (flush_d) begin
            w_ifid_bubble = 1'b1;
            w_ifid_load   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_RUN;
            r_pc_f       <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pcplus4_d  <= '0;
            r_valid_d    <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pc_f       <= w_pc_f_n;
            r_req_addr   <= w_req_addr_n;
            r_hold_instr <= w_hold_instr_n;
            r_hold_pc    <= w_hold_pc_n;
            if (w_ifid_bubble) begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
            end else if (w_ifid_load) begin
                r_instr_d   <= w_ifid_instr;
                r_pc_d      <= w_ifid_pc;
                r_pcplus4_d <= w_ifid_pc + FOUR;
                r_valid_d   <= 1'b1;
            end
        end
    end

    assign imem_req  = !reset && (r_state != S_HOLD);
    assign imem_addr = (r_state == S_DROP) ? r_req_addr : r_pc_f;
    assign instr_d   = r_instr_d;
    assign pc_d      = r_pc_d;
    assign pcplus4_d = r_pcplus4_d;
    assign valid_d   = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic        pc_src_e = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic [31:0] instr_d, pc_d, pcplus4_d;
    logic        valid_d;

    int total = 0;
    int bad = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:16] ^ 16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the program-order view of fetch. m_pc is the next
    // address to fetch; a "stranded" request must still complete at its old
    // address; a "parked" word waits for decode to accept it.
    logic        m_known = 1'b0;
    logic [31:0] m_pc;
    logic        m_stranded;
    logic [31:0] m_stranded_addr;
    logic        m_parked;
    logic [31:0] m_park_pc;
    logic [31:0] e_instr, e_pc, e_pc4;
    logic        e_valid;

    task automatic ifid_bubble_unless_stall();
        if (!stall_d) begin e_instr = NOP; e_valid = 1'b0; end
    endtask

    task automatic ifid_deliver(input logic [31:0] pc);
        e_instr = mem_word(pc);
        e_pc    = pc;
        e_pc4   = pc + 32'd4;
        e_valid = 1'b1;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = {pc_target_e[31:2], 2'b00};
        if (reset) begin
            m_known = 1'b1; m_pc = 32'h0; m_stranded = 1'b0; m_parked = 1'b0;
            m_stranded_addr = '0; m_park_pc = '0;
            e_instr = NOP; e_pc = '0; e_pc4 = '0; e_valid = 1'b0;
        end else if (m_known) begin
            if (m_parked) begin
                if (pc_src_e) begin
                    m_parked = 1'b0; m_pc = tgt; ifid_bubble_unless_stall();
                end else if (!stall_d && !flush_d) begin
                    m_parked = 1'b0; ifid_deliver(m_park_pc);
                end
            end else if (m_stranded) begin
                if (pc_src_e) m_pc = tgt;
                if (imem_ready) m_stranded = 1'b0;
                ifid_bubble_unless_stall();
            end else if (pc_src_e) begin
                if (!imem_ready) begin m_stranded = 1'b1; m_stranded_addr = m_pc; end
                m_pc = tgt;
                ifid_bubble_unless_stall();
            end else if (imem_ready) begin
                if (stall_d || flush_d) begin m_parked = 1'b1; m_park_pc = m_pc; end
                else ifid_deliver(m_pc);
                m_pc = m_pc + 32'd4;
            end else begin
                ifid_bubble_unless_stall();
            end
            if (flush_d) begin e_instr = NOP; e_valid = 1'b0; end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (m_known) begin
                chk("valid_d", {31'b0, valid_d}, {31'b0, e_valid});
                chk("instr_d", instr_d, e_instr);
                if (e_valid) begin
                    chk("pc_d", pc_d, e_pc);
                    chk("pcplus4_d", pcplus4_d, e_pc4);
                end
                chk("imem_req", {31'b0, imem_req}, {31'b0, !reset && !m_parked});
                if (!reset && !m_parked)
                    chk("imem_addr", imem_addr, m_stranded ? m_stranded_addr : m_pc);
            end
            model_step();
        end
    end

    task automatic cyc(input logic rst, input logic rdy, input logic stl, input logic fl,
                       input logic src, input logic [31:0] tgt);
        @(negedge clk);
        reset = rst; imem_ready = rdy; stall_d = stl; flush_d = fl;
        pc_src_e = src; pc_target_e = tgt;
        #2;
    endtask

    logic [3:0] vec [0:23];

    initial begin
        vec = '{4'b1000, 4'b1100, 4'b1100, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b1010,
                4'b1100, 4'b1001, 4'b1000, 4'b0100, 4'b1110, 4'b1000, 4'b0011, 4'b1001,
                4'b1000, 4'b1100, 4'b0101, 4'b1000, 4'b0010, 4'b1011, 4'b1000, 4'b1000};

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit reset valid", {31'b0, valid_d}, 32'd0);
        chk("lit reset instr", instr_d, 32'h0000_0013);
        chk("lit reset addr", imem_addr, 32'h0);
        chk("lit reset req", {31'b0, imem_req}, 32'd1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit first valid", {31'b0, valid_d}, 32'd1);
        chk("lit first pc", pc_d, 32'h0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit wait addr", imem_addr, 32'h8);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit wait bubble", {31'b0, valid_d}, 32'd0);
        chk("lit wait addr held", imem_addr, 32'h8);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit after wait pc", pc_d, 32'h8);
        chk("lit after wait instr", instr_d, 32'hC0DE_0008);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("lit hold req", {31'b0, imem_req}, 32'd0);
        chk("lit hold ifid", pc_d, 32'hC);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit release pc", pc_d, 32'h10);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit next pc", pc_d, 32'h14);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h103);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit drop addr", imem_addr, 32'h20);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit redirect addr", imem_addr, 32'h100);
        cyc(0, 0, 1, 1, 0, 0);
        chk("lit redirect pc", pc_d, 32'h100);
        cyc(0, 1, 0, 1, 0, 0);
        chk("lit flush valid", {31'b0, valid_d}, 32'd0);
        chk("lit flush instr", instr_d, 32'h0000_0013);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h200);
        chk("lit parked word", pc_d, 32'h104);
        cyc(1, 0, 0, 0, 0, 0);
        chk("lit reset in drop req", {31'b0, imem_req}, 32'd0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("lit post reset addr", imem_addr, 32'h0);
        chk("lit post reset valid", {31'b0, valid_d}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit reset in hold addr", imem_addr, 32'h0);
        chk("lit reset in hold req", {31'b0, imem_req}, 32'd1);
        cyc(0, 1, 0, 0, 1, 32'hFFFF_FFFF);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit wrap addr", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lit wrap pc", pc_d, 32'hFFFF_FFFC);
        chk("lit wrap pcplus4", pcplus4_d, 32'h0);
        chk("lit wrap next addr", imem_addr, 32'h0);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] v;
            v = vec[i];
            cyc(0, v[3], v[2], v[1], v[0], 32'h300 + 32'(i * 8) + 32'd1);
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);

        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
